i2c_read_reg_burst: RTL and testbench
=====================================

# i2c_read_reg_burst

Register-read counterpart of the multi-byte I2C register writer. On `start` it drives the shared I2C master command/data interface to write one register-address byte, then issue a repeated-start read of N bytes (1–16). Each byte is streamed out with a valid/ready handshake to the consumer (sensor sample assembler). It uses the shared one-shot timer for every wait and reports `done` / `message_failure` like the other I2C transaction modules.

## Interface
- `TIMER_SEL`, default 4'd1: value driven on `timer_param` for every timeout.
- `clk  in  1`: single clock, all logic on rising edge.
- `reset_n  in  1`: asynchronous assert, active-low; deassertion synchronised externally.
- `start  in  1`: one-cycle request, sampled only in IDLE.
- `dev_address  in  7`, `reg_address  in  8`, `byte_count  in  4`: latched on accepted `start`; `byte_count` 0 means 16.
- `done  out  1`: one-cycle pulse at end of any transaction (success or failure).
- `message_failure  out  1`: one-cycle pulse, coincident with `done`, on failure.
- `busy  out  1`: high in every state except IDLE.
- `timer_start  out  1`, `timer_reset  out  1`, `timer_param  out  4`, `timer_exp  in  1`: shared timer.
- `i2c_dev_address  out  7`, `i2c_cmd_start`, `i2c_cmd_read`, `i2c_cmd_write_multiple`, `i2c_cmd_stop`, `i2c_cmd_valid  out  1`, `i2c_cmd_ready  in  1`: master command port.
- `i2c_data_out  out  8`, `i2c_data_out_valid  out  1`, `i2c_data_out_last  out  1`, `i2c_data_out_ready  in  1`: register-address byte to master.
- `i2c_data_in  in  8`, `i2c_data_in_valid  in  1`, `i2c_data_in_ready  out  1`: read bytes from master.
- `i2c_bus_busy  in  1`, `i2c_bus_active  in  1`, `i2c_missed_ack  in  1`: master status.
- `rd_data  out  8`, `rd_valid  out  1`, `rd_last  out  1`, `rd_ready  in  1`: byte stream to consumer.

## Operation
- States: IDLE, CHECK_BUS, CMD_ADDR, SEND_REG, CMD_READ, RECV, WAIT_FREE, FINISH.
- IDLE: on `start`, latch inputs and set `remaining` (5 bits) = `byte_count` or 16 if 0. Go to CHECK_BUS.
- CHECK_BUS: wait for `~i2c_bus_busy & ~i2c_bus_active`.
- CMD_ADDR: `cmd_valid`=1 with start=1, write_multiple=1, read=0, stop=0. Wait for `cmd_ready`.
- SEND_REG: `data_out`=reg_address, valid=1, last=1. Wait for `data_out_ready`.
- CMD_READ: `cmd_valid`=1, read=1. start=1 only for the first read. stop=1 when `remaining`==1. Wait for `cmd_ready`, then go to RECV.
- RECV: pass-through. `rd_data`=`i2c_data_in`, `rd_valid`=`i2c_data_in_valid`, `i2c_data_in_ready`=`rd_ready`, `rd_last`=(`remaining`==1). On handshake, decrement `remaining`. Go to CMD_READ if >1 before decrement, else WAIT_FREE.
- WAIT_FREE: wait for `~i2c_bus_busy`, then FINISH. FINISH pulses `done` and returns to IDLE.
- Timeouts: on entry to every wait state (CHECK_BUS..WAIT_FREE), pulse `timer_start` and `timer_reset` for one cycle. `timer_exp` while waiting takes the failure path.
- Failure path: deassert all valids, pulse `done` and `message_failure`, return to IDLE.
- `i2c_missed_ack` in any non-IDLE state wins over all other conditions and takes the failure path that cycle.

## Timing
- Reset values: all outputs 0, except `timer_reset`=1 and `timer_param`=`TIMER_SEL`. State = IDLE.
- All outputs registered except the RECV pass-through signals (`rd_data`, `rd_valid`, `i2c_data_in_ready`), which are combinational and zero outside RECV.
- `start`→`cmd_valid` takes at least 2 cycles (IDLE→CHECK_BUS→CMD_ADDR). Each wait state with ready already high costs 1 cycle.
- Valids hold with stable payload until ready. Deassertion happens the cycle after the handshake.
- A consumer stall (`rd_ready`=0) stalls the master and can hit the timeout; the timeout is authoritative.
- `start` while non-IDLE is ignored.
- Async reset mid-transaction: outputs return to reset values immediately, with no `done` pulse.
- `timer_exp` and ready asserted in the same cycle: the handshake wins.

## Structure
- Shared package `i2c_pkg`: state enum encoding, `TIMER_SEL` default, byte-count width (4) and max (16), common to the writer and reader.
- Single module, no sub-module. The 5-bit `remaining` counter and the FSM are inline.

## Test plan
- dev 0x29, reg 0x10, count 2, all readies high, bytes 0xAB, 0xCD:
  - commands: write_multiple(start), read(start), read(stop);
  - `data_out`=0x10 with last=1;
  - `rd_data` 0xAB then 0xCD with `rd_last` on the second;
  - `done` pulse, `message_failure`=0.
- count 0: exactly 16 read commands; stop only on the 16th; `rd_last` on the 16th byte.
- `i2c_missed_ack` during SEND_REG: next cycle all valids 0; `done`=`message_failure`=1 for one cycle; IDLE.
- `cmd_ready` held low in CMD_READ, `timer_exp` after 50 cycles: failure pulse, no `rd_valid` ever asserted.
- `rd_ready` low for 10 cycles with `data_in_valid` high: `i2c_data_in_ready`=0 throughout, byte not lost, accepted on `rd_ready`.
- `reset_n` low during RECV of byte 2 of 4: outputs at reset values immediately; a new `start` completes normally.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C transaction modules: FSM state encoding,
// default timer selection and byte-count sizing.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CHECK_BUS = 3'd1,
        ST_CMD_ADDR  = 3'd2,
        ST_SEND_REG  = 3'd3,
        ST_CMD_READ  = 3'd4,
        ST_RECV      = 3'd5,
        ST_WAIT_FREE = 3'd6,
        ST_FINISH    = 3'd7
    } i2c_state_e;

    localparam logic [3:0] TIMER_SEL_DEFAULT = 4'd1;
    localparam int         BYTE_CNT_W        = 4;
    localparam int         BYTE_MAX          = 16;
    localparam int         REMAIN_W          = 5;

    // A byte_count of zero encodes the maximum burst length.
    function automatic logic [REMAIN_W-1:0] byte_count_to_remaining(
        input logic [BYTE_CNT_W-1:0] cnt
    );
        logic [REMAIN_W-1:0] result;
        if (cnt == '0) begin
            result = REMAIN_W'(BYTE_MAX);
        end else begin
            result = {1'b0, cnt};
        end
        return result;
    endfunction

endpackage

// File: rtl/i2c_read_reg_burst.sv
// Register burst reader: writes one register-address byte to the device,
// then reads 1..16 bytes with repeated-start, streaming each byte to the
// consumer through a valid/ready pass-through. Every wait is guarded by the
// shared one-shot timer; a missed ACK aborts from any busy state.
module i2c_read_reg_burst
    import i2c_pkg::*;
#(
    parameter logic [3:0] TIMER_SEL = TIMER_SEL_DEFAULT
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [6:0] dev_address,
    input  logic [7:0] reg_address,
    input  logic [3:0] byte_count,
    output logic       done,
    output logic       message_failure,
    output logic       busy,
    output logic       timer_start,
    output logic       timer_reset,
    output logic [3:0] timer_param,
    input  logic       timer_exp,
    output logic [6:0] i2c_dev_address,
    output logic       i2c_cmd_start,
    output logic       i2c_cmd_read,
    output logic       i2c_cmd_write_multiple,
    output logic       i2c_cmd_stop,
    output logic       i2c_cmd_valid,
    input  logic       i2c_cmd_ready,
    output logic [7:0] i2c_data_out,
    output logic       i2c_data_out_valid,
    output logic       i2c_data_out_last,
    input  logic       i2c_data_out_ready,
    input  logic [7:0] i2c_data_in,
    input  logic       i2c_data_in_valid,
    output logic       i2c_data_in_ready,
    input  logic       i2c_bus_busy,
    input  logic       i2c_bus_active,
    input  logic       i2c_missed_ack,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       rd_last,
    input  logic       rd_ready
);

    i2c_state_e          state_q;
    logic [REMAIN_W-1:0] remaining_q;
    logic                first_read_q;
    logic [6:0]          dev_q;
    logic [7:0]          reg_addr_q;
    logic                busy_q;
    logic                done_q;
    logic                fail_q;
    logic                timer_start_q;
    logic                timer_reset_q;
    logic [3:0]          timer_param_q;
    logic                cmd_valid_q;
    logic                cmd_start_q;
    logic                cmd_read_q;
    logic                cmd_wm_q;
    logic                cmd_stop_q;
    logic                dout_valid_q;
    logic                dout_last_q;
    logic                rd_last_q;

    logic                advance;
    logic                waiting;
    logic                fail_now;
    logic                in_recv;

    // Condition that lets the current wait state move on this cycle.
    always_comb begin
        advance = 1'b0;
        case (state_q)
            ST_CHECK_BUS: advance = ~i2c_bus_busy & ~i2c_bus_active;
            ST_CMD_ADDR:  advance = i2c_cmd_ready;
            ST_SEND_REG:  advance = i2c_data_out_ready;
            ST_CMD_READ:  advance = i2c_cmd_ready;
            ST_RECV:      advance = i2c_data_in_valid & rd_ready;
            ST_WAIT_FREE: advance = ~i2c_bus_busy;
            default:      advance = 1'b0;
        endcase
    end

    // A completed handshake beats a simultaneous timeout; a missed ACK beats everything.
    assign waiting  = (state_q != ST_IDLE) && (state_q != ST_FINISH);
    assign fail_now = (state_q != ST_IDLE) &&
                      (i2c_missed_ack || (waiting && timer_exp && !advance));

    // Byte stream is passed straight through while receiving, silent otherwise.
    assign in_recv           = (state_q == ST_RECV);
    assign rd_data           = in_recv ? i2c_data_in : 8'h00;
    assign rd_valid          = in_recv & i2c_data_in_valid;
    assign i2c_data_in_ready = in_recv & rd_ready;

    // Transaction sequencer; every registered output is set on the transition into a state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            remaining_q   <= '0;
            first_read_q  <= 1'b0;
            dev_q         <= '0;
            reg_addr_q    <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            fail_q        <= 1'b0;
            timer_start_q <= 1'b0;
            timer_reset_q <= 1'b1;
            timer_param_q <= TIMER_SEL;
            cmd_valid_q   <= 1'b0;
            cmd_start_q   <= 1'b0;
            cmd_read_q    <= 1'b0;
            cmd_wm_q      <= 1'b0;
            cmd_stop_q    <= 1'b0;
            dout_valid_q  <= 1'b0;
            dout_last_q   <= 1'b0;
            rd_last_q     <= 1'b0;
        end else begin
            timer_start_q <= 1'b0;
            timer_reset_q <= 1'b0;
            timer_param_q <= TIMER_SEL;
            done_q        <= 1'b0;
            fail_q        <= 1'b0;
            if (fail_now) begin
                state_q       <= ST_IDLE;
                busy_q        <= 1'b0;
                done_q        <= 1'b1;
                fail_q        <= 1'b1;
                timer_reset_q <= 1'b1;
                cmd_valid_q   <= 1'b0;
                dout_valid_q  <= 1'b0;
                dout_last_q   <= 1'b0;
                rd_last_q     <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        // Timer is held in reset while nothing is in flight.
                        timer_reset_q <= 1'b1;
                        if (start) begin
                            dev_q         <= dev_address;
                            reg_addr_q    <= reg_address;
                            remaining_q   <= byte_count_to_remaining(byte_count);
                            first_read_q  <= 1'b1;
                            busy_q        <= 1'b1;
                            timer_start_q <= 1'b1;
                            state_q       <= ST_CHECK_BUS;
                        end
                    end
                    ST_CHECK_BUS: begin
                        if (advance) begin
                            cmd_valid_q   <= 1'b1;
                            cmd_start_q   <= 1'b1;
                            cmd_read_q    <= 1'b0;
                            cmd_wm_q      <= 1'b1;
                            cmd_stop_q    <= 1'b0;
                            timer_start_q <= 1'b1;
                            timer_reset_q <= 1'b1;
                            state_q       <= ST_CMD_ADDR;
                        end
                    end
                    ST_CMD_ADDR: begin
                        if (advance) begin
                            cmd_valid_q   <= 1'b0;
                            dout_valid_q  <= 1'b1;
                            dout_last_q   <= 1'b1;
                            timer_start_q <= 1'b1;
                            timer_reset_q <= 1'b1;
                            state_q       <= ST_SEND_REG;
                        end
                    end
                    ST_SEND_REG: begin
                        if (advance) begin
                            dout_valid_q  <= 1'b0;
                            dout_last_q   <= 1'b0;
                            cmd_valid_q   <= 1'b1;
                            cmd_start_q   <= first_read_q;
                            cmd_read_q    <= 1'b1;
                            cmd_wm_q      <= 1'b0;
                            cmd_stop_q    <= (remaining_q == 5'd1);
                            timer_start_q <= 1'b1;
                            timer_reset_q <= 1'b1;
                            state_q       <= ST_CMD_READ;
                        end
                    end
                    ST_CMD_READ: begin
                        if (advance) begin
                            cmd_valid_q   <= 1'b0;
                            first_read_q  <= 1'b0;
                            rd_last_q     <= (remaining_q == 5'd1);
                            timer_start_q <= 1'b1;
                            timer_reset_q <= 1'b1;
                            state_q       <= ST_RECV;
                        end
                    end
                    ST_RECV: begin
                        if (advance) begin
                            remaining_q   <= remaining_q - 5'd1;
                            rd_last_q     <= 1'b0;
                            timer_start_q <= 1'b1;
                            timer_reset_q <= 1'b1;
                            if (remaining_q > 5'd1) begin
                                // Next read: repeated start already issued, stop on the final byte.
                                cmd_valid_q <= 1'b1;
                                cmd_start_q <= 1'b0;
                                cmd_read_q  <= 1'b1;
                                cmd_wm_q    <= 1'b0;
                                cmd_stop_q  <= (remaining_q == 5'd2);
                                state_q     <= ST_CMD_READ;
                            end else begin
                                state_q     <= ST_WAIT_FREE;
                            end
                        end
                    end
                    ST_WAIT_FREE: begin
                        if (advance) begin
                            state_q <= ST_FINISH;
                        end
                    end
                    ST_FINISH: begin
                        // done lands in the first IDLE cycle, same as on the failure path.
                        done_q        <= 1'b1;
                        busy_q        <= 1'b0;
                        timer_reset_q <= 1'b1;
                        state_q       <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign done                   = done_q;
    assign message_failure        = fail_q;
    assign busy                   = busy_q;
    assign timer_start            = timer_start_q;
    assign timer_reset            = timer_reset_q;
    assign timer_param            = timer_param_q;
    assign i2c_dev_address        = dev_q;
    assign i2c_cmd_start          = cmd_start_q;
    assign i2c_cmd_read           = cmd_read_q;
    assign i2c_cmd_write_multiple = cmd_wm_q;
    assign i2c_cmd_stop           = cmd_stop_q;
    assign i2c_cmd_valid          = cmd_valid_q;
    assign i2c_data_out           = reg_addr_q;
    assign i2c_data_out_valid     = dout_valid_q;
    assign i2c_data_out_last      = dout_last_q;
    assign rd_last                = rd_last_q;

endmodule

// File: tb/tb_i2c_read_reg_burst.sv
// Scoreboard bench for i2c_read_reg_burst: a small I2C master emulator answers
// commands and supplies read bytes, stimulus pushes the expected transaction
// sequence into a queue, and a monitor pops and compares each observed event.
module tb_i2c_read_reg_burst;

    localparam logic [3:0] TSEL = 4'd1;
    localparam int K_CMD  = 1;
    localparam int K_DOUT = 2;
    localparam int K_RD   = 3;
    localparam int K_DONE = 4;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [6:0] dev_address;
    logic [7:0] reg_address;
    logic [3:0] byte_count;
    logic       done;
    logic       message_failure;
    logic       busy;
    logic       timer_start;
    logic       timer_reset;
    logic [3:0] timer_param;
    logic       timer_exp;
    logic [6:0] i2c_dev_address;
    logic       i2c_cmd_start;
    logic       i2c_cmd_read;
    logic       i2c_cmd_write_multiple;
    logic       i2c_cmd_stop;
    logic       i2c_cmd_valid;
    logic       i2c_cmd_ready;
    logic [7:0] i2c_data_out;
    logic       i2c_data_out_valid;
    logic       i2c_data_out_last;
    logic       i2c_data_out_ready;
    logic [7:0] i2c_data_in;
    logic       i2c_data_in_valid;
    logic       i2c_data_in_ready;
    logic       i2c_bus_busy;
    logic       i2c_bus_active;
    logic       i2c_missed_ack;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_last;
    logic       rd_ready;

    i2c_read_reg_burst #(.TIMER_SEL(TSEL)) dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .start                  (start),
        .dev_address            (dev_address),
        .reg_address            (reg_address),
        .byte_count             (byte_count),
        .done                   (done),
        .message_failure        (message_failure),
        .busy                   (busy),
        .timer_start            (timer_start),
        .timer_reset            (timer_reset),
        .timer_param            (timer_param),
        .timer_exp              (timer_exp),
        .i2c_dev_address        (i2c_dev_address),
        .i2c_cmd_start          (i2c_cmd_start),
        .i2c_cmd_read           (i2c_cmd_read),
        .i2c_cmd_write_multiple (i2c_cmd_write_multiple),
        .i2c_cmd_stop           (i2c_cmd_stop),
        .i2c_cmd_valid          (i2c_cmd_valid),
        .i2c_cmd_ready          (i2c_cmd_ready),
        .i2c_data_out           (i2c_data_out),
        .i2c_data_out_valid     (i2c_data_out_valid),
        .i2c_data_out_last      (i2c_data_out_last),
        .i2c_data_out_ready     (i2c_data_out_ready),
        .i2c_data_in            (i2c_data_in),
        .i2c_data_in_valid      (i2c_data_in_valid),
        .i2c_data_in_ready      (i2c_data_in_ready),
        .i2c_bus_busy           (i2c_bus_busy),
        .i2c_bus_active         (i2c_bus_active),
        .i2c_missed_ack         (i2c_missed_ack),
        .rd_data                (rd_data),
        .rd_valid               (rd_valid),
        .rd_last                (rd_last),
        .rd_ready               (rd_ready)
    );

    typedef struct {
        int          kind;
        logic [15:0] val;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] byte_q[$];     // bytes the emulated master will return
    logic [7:0] txn_bytes[$];  // bytes chosen for the transaction being issued

    int total = 0;
    int bad   = 0;
    int ts_cnt = 0;
    int rd_hs_cnt = 0;
    int rd_valid_cnt = 0;
    int txn_no = 0;

    bit all_ready      = 0;
    bit hold_dout_low  = 0;
    bit block_read_cmd = 0;
    bit force_rd_low   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic sb_pop(input int kind, input logic [15:0] val, input string nm);
        exp_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s: unexpected event value=%h, nothing pending", nm, val);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val !== val) begin
                bad++;
                $display("FAIL %s: got kind=%0d value=%h expected kind=%0d value=%h",
                         nm, kind, val, e.kind, e.val);
            end
        end
    endtask

    task automatic model_push(input int kind, input logic [15:0] val);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    function automatic logic [15:0] cmd_word(input logic [6:0] dev, input bit st,
                                             input bit rd, input bit wm, input bit sp);
        return {5'b0, dev, st, rd, wm, sp};
    endfunction

    // Monitor: every handshake or completion pulse is matched against the queue.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (timer_start) ts_cnt++;
                if (rd_valid) rd_valid_cnt++;
                if (i2c_cmd_valid && i2c_cmd_ready)
                    sb_pop(K_CMD, {5'b0, i2c_dev_address, i2c_cmd_start, i2c_cmd_read,
                                   i2c_cmd_write_multiple, i2c_cmd_stop}, "cmd");
                if (i2c_data_out_valid && i2c_data_out_ready)
                    sb_pop(K_DOUT, {7'b0, i2c_data_out, i2c_data_out_last}, "data_out");
                if (rd_valid && rd_ready) begin
                    rd_hs_cnt++;
                    sb_pop(K_RD, {7'b0, rd_data, rd_last}, "rd");
                end
                if (done || message_failure)
                    sb_pop(K_DONE, {14'b0, done, message_failure}, "done");
            end
        end
    end

    // Emulated I2C master, bus status and consumer.
    initial begin
        bit rd_cmd_hs;
        bit din_hs;
        int pending;
        pending = 0;
        i2c_cmd_ready = 0; i2c_data_out_ready = 0; i2c_data_in = 8'h00;
        i2c_data_in_valid = 0; i2c_bus_busy = 0; i2c_bus_active = 0; rd_ready = 0;
        forever begin
            @(negedge clk);
            rd_cmd_hs = reset_n && i2c_cmd_valid && i2c_cmd_ready && i2c_cmd_read;
            din_hs    = reset_n && i2c_data_in_valid && i2c_data_in_ready;
            @(posedge clk);
            #1;
            if (!reset_n) begin
                pending = 0;
                i2c_data_in_valid = 0;
                byte_q.delete();
            end else begin
                if (rd_cmd_hs) pending++;
                if (din_hs) i2c_data_in_valid = 0;
                if (!i2c_data_in_valid && pending > 0 && byte_q.size() > 0 &&
                    (all_ready || $urandom_range(0, 2) != 0)) begin
                    i2c_data_in       = byte_q.pop_front();
                    i2c_data_in_valid = 1;
                    pending--;
                end
            end
            i2c_cmd_ready      = (block_read_cmd && i2c_cmd_read) ? 1'b0
                                 : (all_ready || $urandom_range(0, 3) != 0);
            i2c_data_out_ready = hold_dout_low ? 1'b0 : (all_ready || $urandom_range(0, 3) != 0);
            rd_ready           = force_rd_low ? 1'b0 : (all_ready || $urandom_range(0, 3) != 0);
            i2c_bus_busy       = all_ready ? 1'b0 : ($urandom_range(0, 3) == 0);
            i2c_bus_active     = all_ready ? 1'b0 : ($urandom_range(0, 7) == 0);
        end
    end

    task automatic pulse_start(input logic [6:0] dev, input logic [7:0] rg, input logic [3:0] cnt);
        @(posedge clk); #1;
        start = 1; dev_address = dev; reg_address = rg; byte_count = cnt;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic fill_random(input int n);
        txn_bytes.delete();
        for (int i = 0; i < n; i++) txn_bytes.push_back(8'($urandom_range(0, 255)));
    endtask

    // Reference: one address write, then N reads; start on the first, stop and last on the final.
    task automatic start_txn(input logic [6:0] dev, input logic [7:0] rg, input logic [3:0] cnt);
        int n;
        n = (cnt == 4'd0) ? 16 : int'(cnt);
        model_push(K_CMD, cmd_word(dev, 1'b1, 1'b0, 1'b1, 1'b0));
        model_push(K_DOUT, {7'b0, rg, 1'b1});
        for (int i = 0; i < n; i++) begin
            model_push(K_CMD, cmd_word(dev, i == 0, 1'b1, 1'b0, i == n - 1));
            model_push(K_RD, {7'b0, txn_bytes[i], i == n - 1});
            byte_q.push_back(txn_bytes[i]);
        end
        model_push(K_DONE, 16'h0002);
        pulse_start(dev, rg, cnt);
    endtask

    task automatic recover_reset();
        reset_n = 0;
        repeat (3) @(posedge clk);
        exp_q.delete();
        @(negedge clk);
        reset_n = 1;
    endtask

    task automatic wait_done(input string nm);
        bit seen;
        seen = 0;
        for (int c = 0; c < 4000 && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check({nm, "_done_seen"}, 32'(seen), 32'd1);
        @(posedge clk); #1;
        check({nm, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        if (!seen) recover_reset();
    endtask

    task automatic run_full(input logic [6:0] dev, input logic [7:0] rg, input logic [3:0] cnt,
                            input bit poke_start);
        int n;
        int ts_base;
        n = (cnt == 4'd0) ? 16 : int'(cnt);
        ts_base = ts_cnt;
        start_txn(dev, rg, cnt);
        if (poke_start) begin
            // A second request while busy must be ignored.
            @(posedge clk); #1;
            start = 1; dev_address = ~dev; reg_address = ~rg; byte_count = cnt + 4'd1;
            @(posedge clk); #1;
            start = 0;
        end
        wait_done("txn");
        check("timer_starts", 32'(ts_cnt - ts_base), 32'(4 + 2 * n));
        txn_no++;
        $display("txn %0d: dev=%h reg=%h count=%0d bytes=%0d", txn_no, dev, rg, cnt, n);
    endtask

    initial begin
        int base;
        int lowcnt;
        bit seen;
        reset_n = 0; start = 0; dev_address = 0; reg_address = 0; byte_count = 0;
        timer_exp = 0; i2c_missed_ack = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_valid", 32'(i2c_cmd_valid), 0);
        check("rst_dout_valid", 32'(i2c_data_out_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_timer_reset", 32'(timer_reset), 1);
        check("rst_timer_param", 32'(timer_param), 32'(TSEL));
        check("rst_rd_valid", 32'(rd_valid), 0);
        @(negedge clk);
        reset_n = 1;

        // Directed burst of two with everything ready.
        all_ready = 1;
        txn_bytes.delete();
        txn_bytes.push_back(8'hAB);
        txn_bytes.push_back(8'hCD);
        run_full(7'h29, 8'h10, 4'd2, 1'b0);
        all_ready = 0;

        // Maximum burst encoded as zero.
        fill_random(16);
        run_full(7'($urandom_range(0, 127)), 8'($urandom_range(0, 255)), 4'd0, 1'b1);

        // Randomized bursts under random readiness.
        for (int t = 0; t < 10; t++) begin
            logic [3:0] c;
            c = 4'($urandom_range(0, 15));
            fill_random((c == 4'd0) ? 16 : int'(c));
            run_full(7'($urandom_range(0, 127)), 8'($urandom_range(0, 255)), c, t[0]);
        end

        // Missed ACK while the register byte is pending.
        hold_dout_low = 1;
        model_push(K_CMD, cmd_word(7'h11, 1'b1, 1'b0, 1'b1, 1'b0));
        model_push(K_DONE, 16'h0003);
        pulse_start(7'h11, 8'h22, 4'd3);
        seen = 0;
        for (int c = 0; c < 500 && !seen; c++) begin
            @(negedge clk);
            if (i2c_data_out_valid) seen = 1;
        end
        check("nack_reached_send_reg", 32'(seen), 1);
        @(posedge clk); #1;
        i2c_missed_ack = 1;
        @(posedge clk); #1;
        i2c_missed_ack = 0;
        check("nack_dout_valid", 32'(i2c_data_out_valid), 0);
        check("nack_cmd_valid", 32'(i2c_cmd_valid), 0);
        check("nack_done_mf", 32'({done, message_failure}), 32'h3);
        check("nack_busy", 32'(busy), 0);
        @(posedge clk); #1;
        check("nack_done_one_cycle", 32'({done, message_failure}), 0);
        check("nack_queue_empty", 32'(exp_q.size()), 0);
        hold_dout_low = 0;
        txn_no++;
        $display("txn %0d: missed ack during register byte", txn_no);

        // Read command never accepted; timeout after 50 cycles.
        block_read_cmd = 1;
        base = rd_valid_cnt;
        model_push(K_CMD, cmd_word(7'h33, 1'b1, 1'b0, 1'b1, 1'b0));
        model_push(K_DOUT, {7'b0, 8'h44, 1'b1});
        model_push(K_DONE, 16'h0003);
        pulse_start(7'h33, 8'h44, 4'd2);
        seen = 0;
        for (int c = 0; c < 500 && !seen; c++) begin
            @(negedge clk);
            if (i2c_cmd_valid && i2c_cmd_read) seen = 1;
        end
        check("tmo_reached_cmd_read", 32'(seen), 1);
        lowcnt = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (!i2c_cmd_valid) lowcnt++;
        end
        check("tmo_cmd_valid_held", 32'(lowcnt), 0);
        @(posedge clk); #1;
        timer_exp = 1;
        @(posedge clk); #1;
        timer_exp = 0;
        check("tmo_done_mf", 32'({done, message_failure}), 32'h3);
        check("tmo_cmd_valid", 32'(i2c_cmd_valid), 0);
        @(posedge clk); #1;
        check("tmo_no_rd_valid", 32'(rd_valid_cnt - base), 0);
        check("tmo_queue_empty", 32'(exp_q.size()), 0);
        block_read_cmd = 0;
        txn_no++;
        $display("txn %0d: read command timeout", txn_no);

        // Consumer stall for 10 cycles with a byte waiting.
        force_rd_low = 1;
        fill_random(2);
        start_txn(7'h55, 8'h66, 4'd2);
        seen = 0;
        for (int c = 0; c < 500 && !seen; c++) begin
            @(negedge clk);
            if (rd_valid) seen = 1;
        end
        check("stall_byte_presented", 32'(seen), 1);
        for (int c = 0; c < 10; c++) begin
            check("stall_data_in_ready", 32'(i2c_data_in_ready), 0);
            check("stall_rd_data", 32'({rd_valid, rd_data}), 32'({1'b1, txn_bytes[0]}));
            @(negedge clk);
        end
        force_rd_low = 0;
        wait_done("stall");
        txn_no++;
        $display("txn %0d: consumer stall of 10 cycles", txn_no);

        // Reset while the second of four bytes is being received.
        fill_random(4);
        base = rd_hs_cnt;
        start_txn(7'h12, 8'h34, 4'd4);
        seen = 0;
        for (int c = 0; c < 2000 && !seen; c++) begin
            @(negedge clk);
            if (rd_hs_cnt == base + 1 && rd_valid) seen = 1;
        end
        check("rst_mid_reached_byte2", 32'(seen), 1);
        #2;
        reset_n = 0;
        #1;
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_rd_valid", 32'(rd_valid), 0);
        check("rst_mid_din_ready", 32'(i2c_data_in_ready), 0);
        check("rst_mid_timer", 32'({timer_reset, timer_param}), 32'({1'b1, TSEL}));
        check("rst_mid_done", 32'({done, message_failure}), 0);
        repeat (3) @(posedge clk);
        exp_q.delete();
        @(negedge clk);
        reset_n = 1;
        txn_no++;
        $display("txn %0d: reset during byte 2 of 4", txn_no);

        fill_random(3);
        run_full(7'h5A, 8'hA5, 4'd3, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
